// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared op codes, FSM states and op decode helpers for serial_alu
// Contents:
//   OP_*       3-bit operation codes
//   state_t    control FSM states
//   is_arith() op uses the adder (ADD/SUB/SLT/SLTU)
//   inv_b()    op uses ~B (ANDN/ORN/SUB/SLT/SLTU)
package serial_alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return op[1];
    endfunction

    // SLTU (011) subtracts even though op[2] is clear
    function automatic logic inv_b(input logic [2:0] op);
        return op[2] | (op[1] & op[0]);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// alu_digit: one DIGIT-wide combinational ALU slice, reused for every digit
// Ports:
//   a_d, b_d  operand digits
//   cin       carry into the digit LSB
//   op        operation code
//   r_d       digit result
//   cout      carry out of the digit MSB
//   c_msb_in  carry into the digit MSB, for signed overflow
module alu_digit
    import serial_alu_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [DIGIT-1:0] r_d,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT-1:0] bb;
    logic [DIGIT:0]   sum;

    always_comb begin
        bb       = inv_b(op) ? ~b_d : b_d;
        sum      = {1'b0, a_d} + {1'b0, bb} + {{DIGIT{1'b0}}, cin};
        r_d      = is_arith(op) ? sum[DIGIT-1:0] : op[0] ? (a_d | bb) : (a_d & bb);
        cout     = sum[DIGIT];
        // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the xor
        c_msb_in = a_d[DIGIT-1] ^ bb[DIGIT-1] ^ sum[DIGIT-1];
    end

endmodule

// File: rtl/serial_alu.sv
// serial_alu: digit-serial ALU, WIDTH bits processed DIGIT bits per clock
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid, in_ready, a, b, op   operation request handshake
//   out_valid, out_ready     result handshake
//   result, zero, carry, overflow  result and flags, held while out_valid
//   busy                     an operation is in flight or awaiting pickup
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = NDIG > 1 ? $clog2(NDIG) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_alu: WIDTH must be a multiple of DIGIT");
    end

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_ins, res_fin;
    logic [2:0]       op_q;
    logic             c_q, zero_q, carry_q, ovf_q;
    logic [KW-1:0]    k_q;
    logic [DIGIT-1:0] r_d;
    logic             cout, c_msb_in, last, slt_bit, is_slt;

    // operands shift right each digit, so the slice always sees the low DIGIT bits
    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d      (a_q[DIGIT-1:0]),
        .b_d      (b_q[DIGIT-1:0]),
        .cin      (c_q),
        .op       (op_q),
        .r_d      (r_d),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

    always_comb begin
        last    = k_q == KW'(NDIG - 1);
        res_ins = res_q;
        res_ins[32'(k_q) * DIGIT +: DIGIT] = r_d;
        // SLT: sign of A-B corrected by overflow; SLTU: borrow out
        slt_bit = op_q[2] ? r_d[DIGIT-1] ^ c_msb_in ^ cout : ~cout;
        is_slt  = is_arith(op_q) & op_q[0];
        res_fin = is_slt ? WIDTH'(slt_bit) : res_ins;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    op_q    <= op;
                    c_q     <= is_arith(op) & inv_b(op);
                    k_q     <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    c_q   <= cout;
                    k_q   <= k_q + KW'(1);
                    res_q <= last ? res_fin : res_ins;
                    if (last) begin
                        zero_q  <= res_fin == '0;
                        carry_q <= is_arith(op_q) & cout;
                        ovf_q   <= is_arith(op_q) & ~op_q[0] & (c_msb_in ^ cout);
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign result    = res_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule
